// File: rtl/reg_file_if.sv
// Bus bundle between the ALU-side requester and reg_file.
// Carries one write port and a pair of operand read ports that share a request strobe.
interface reg_file_if #(
  parameter int W  = 32,
  parameter int AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic          rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/reg_file.sv
// ALU register file: one write port, two registered read ports with a valid strobe.
// Entry 0 reads as zero; same-edge write/read of a live entry forwards the write data.
module reg_file #(
  parameter int W  = 32,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);

  localparam logic [AW:0] NUM_ENTRIES = (AW+1)'(N);

  logic [W-1:0] mem_r [1:N-1];
  logic [W-1:0] rd_data_a_r;
  logic [W-1:0] rd_data_b_r;
  logic         rd_valid_r;
  logic [W-1:0] stored_a_s;
  logic [W-1:0] stored_b_s;
  logic [W-1:0] next_a_s;
  logic [W-1:0] next_b_s;
  logic         bypass_a_s;
  logic         bypass_b_s;

  function automatic logic addr_live(input logic [AW-1:0] addr);
    return (addr != '0) && ({1'b0, addr} < NUM_ENTRIES);
  endfunction

  // Entry storage; address 0 and addresses >= N match no entry, so such writes vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < N; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < N; i++) begin
        if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
          mem_r[i] <= bus.wr_data;
        end
      end
    end
  end

  // AND-OR read mux: unmatched addresses (0 and >= N) naturally yield zero.
  always_comb begin
    stored_a_s = '0;
    stored_b_s = '0;
    for (int i = 1; i < N; i++) begin
      stored_a_s = stored_a_s | (mem_r[i] & {W{bus.rd_addr_a == AW'(i)}});
      stored_b_s = stored_b_s | (mem_r[i] & {W{bus.rd_addr_b == AW'(i)}});
    end
  end

  assign bypass_a_s = bus.wr_en && (bus.rd_addr_a == bus.wr_addr) && addr_live(bus.rd_addr_a);
  assign bypass_b_s = bus.wr_en && (bus.rd_addr_b == bus.wr_addr) && addr_live(bus.rd_addr_b);
  assign next_a_s   = bypass_a_s ? bus.wr_data : stored_a_s;
  assign next_b_s   = bypass_b_s ? bus.wr_data : stored_b_s;

  // Registered read results; data holds between requests, valid is a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a_r <= '0;
      rd_data_b_r <= '0;
      rd_valid_r  <= 1'b0;
    end else begin
      rd_valid_r <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_a_r <= next_a_s;
        rd_data_b_r <= next_b_s;
      end
    end
  end

  assign bus.rd_data_a = rd_data_a_r;
  assign bus.rd_data_b = rd_data_b_r;
  assign bus.rd_valid  = rd_valid_r;

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Multi-entry register file for the ALU datapath: one write port, two read ports.
- Writes commit on the clock edge. Reads are registered, with one-cycle latency and a valid strobe.
- Entry 0 always reads as zero.
- The write port is the storage/writer end; the two read ports are the consumer end that feeds ALU operands.

Parameters:
- W, 32, data width of each entry in bits.
- N, 8, number of entries; legal range 2..2**AW.
- AW, 3, address width in bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write enable, sampled on rising clk.
- wr_addr  input  AW  write address.
- wr_data  input  W  write data.
- rd_req  input  1  read request; samples both read addresses on rising clk.
- rd_addr_a  input  AW  operand A read address.
- rd_addr_b  input  AW  operand B read address.
- rd_data_a  output  W  registered operand A data.
- rd_data_b  output  W  registered operand B data.
- rd_valid  output  1  high for exactly one cycle when rd_data_a/b hold the result of the previous cycle's rd_req.

Behaviour:
- Reset: rst high asynchronously clears all N entries, rd_data_a, rd_data_b and rd_valid to 0, without waiting for clk.
  - While rst is high, writes and reads are ignored.
  - Deassertion takes effect at the next rising clk.
- Write: on a rising clk with wr_en=1, entry[wr_addr] <= wr_data.
  - Writes to address 0 are discarded.
  - Writes to addresses >= N are discarded.
  - No other entry changes.
- Read: on a rising clk with rd_req=1:
  - rd_data_a <= value(rd_addr_a) and rd_data_b <= value(rd_addr_b).
  - rd_valid <= 1 on that edge, so data and valid appear in the cycle after the request (latency 1).
- Read value rules:
  - Address 0 returns 0.
  - Addresses >= N return 0.
  - Otherwise the value is the entry contents, subject to the bypass rule below.
- Bypass: if wr_en=1 and rd_req=1 on the same edge, and wr_addr equals a read address that is nonzero and < N, that read port returns wr_data (write-first).
  - Each port is checked independently, so both ports may bypass on the same edge.
- No request: on a rising clk with rd_req=0, rd_valid <= 0 and rd_data_a/b hold their previous values.
- Back-to-back requests: rd_req held high for k cycles gives rd_valid high for k consecutive cycles, one result per cycle. There are no stalls and no backpressure.
- Simultaneous events:
  - A read and a write in the same cycle are always legal.
  - A_addr == B_addr returns identical data on both ports.
- Reset mid-operation: rst asserted while rd_valid=1 drops rd_valid and both data outputs to 0 immediately (asynchronously). A request pending in the same cycle is lost.
- Storage: entry 0 need not be physically stored; the zero-read and write-discard behaviour is the required external view.
- Timing: no combinational path from any input to any output; all outputs come straight from flops.

Test Plan:
- Reset and zero read: assert rst, release, then rd_req with A=1, B=7 -> next cycle rd_valid=1, rd_data_a=0, rd_data_b=0.
- Write then read: write 0xDEADBEEF to addr 3, then 0x12345678 to addr 5; request A=3, B=5 -> one cycle later rd_data_a=0xDEADBEEF, rd_data_b=0x12345678, rd_valid=1; the following idle cycle gives rd_valid=0 with data held.
- Hardwired zero: write 0xFFFFFFFF to addr 0, then read A=0, B=0 -> both outputs 0x00000000.
- Bypass: entry 4 holds 0x11111111; in one cycle drive wr_en=1, wr_addr=4, wr_data=0xCAFEF00D and rd_req=1, A=4, B=2 (2 holds 0x22) -> rd_data_a=0xCAFEF00D, rd_data_b=0x00000022.
- Streaming: hold rd_req high 4 cycles reading A=1,2,3,4 (preloaded 10,20,30,40) -> rd_valid high for 4 cycles with rd_data_a sequence 10,20,30,40, each one cycle after its request.
- Async reset mid-stream: with rd_valid=1 and rd_data_a=40, pulse rst between clock edges -> outputs go to 0 before the next edge; a subsequent read of addr 4 returns 0.
